// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - divider request/response bundle between EX and div_unit
interface div_unit_if;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  modport master (
    output start, annul, signed_div, a, b,
    input  result, ready, busy
  );

  modport slave (
    input  start, annul, signed_div, a, b,
    output result, ready, busy
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-iteration restoring divider returning {remainder, quotient}
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  dif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DIVZERO = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] bmag_q, bmag_d;
  logic        sgn_q, sgn_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic [63:0] result_q, result_d;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] new_rem;
  logic [31:0] new_quo;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    bmag_d   = bmag_q;
    sgn_d    = sgn_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    result_d = result_q;

    // One restoring step: the dividend register fills with quotient bits from the right.
    shifted = {rem_q, dvd_q[31]};
    diff    = shifted - {1'b0, bmag_q};
    qbit    = ~diff[32];
    new_rem = qbit ? diff[31:0] : shifted[31:0];
    new_quo = {dvd_q[30:0], qbit};
    quo_fix = (sgn_q && (a_neg_q ^ b_neg_q)) ? (32'd0 - new_quo) : new_quo;
    rem_fix = (sgn_q && a_neg_q) ? (32'd0 - new_rem) : new_rem;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    a_mag = (dif.signed_div && dif.a[31]) ? (32'd0 - dif.a) : dif.a;
    b_mag = (dif.signed_div && dif.b[31]) ? (32'd0 - dif.b) : dif.b;

    case (state_q)
      S_IDLE: begin
        if (dif.start) begin
          sgn_d   = dif.signed_div;
          a_neg_d = dif.a[31];
          b_neg_d = dif.b[31];
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          dvd_d   = a_mag;
          bmag_d  = b_mag;
          state_d = (dif.b == 32'd0) ? S_DIVZERO : S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = new_rem;
        dvd_d = new_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          result_d = {rem_fix, quo_fix};
          state_d  = S_DONE;
        end
      end
      S_DIVZERO: begin
        result_d = 64'h0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (!dif.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over everything but reset; the last result is left intact.
    if (dif.annul) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      dvd_q    <= 32'd0;
      bmag_q   <= 32'd0;
      sgn_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      bmag_q   <= bmag_d;
      sgn_q    <= sgn_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      result_q <= result_d;
    end
  end

  assign dif.result = result_q;
  assign dif.ready  = (state_q == S_DONE);
  assign dif.busy   = (state_q == S_BUSY) || (state_q == S_DIVZERO);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and random checks of div_unit against an arithmetic model
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  div_unit_if dif ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'h0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble);
    int k;
    int busy_n;
    logic [63:0] exp;
    exp = ref_div(s, a, b);
    dif.signed_div = s;
    dif.a = a;
    dif.b = b;
    dif.start = 1'b1;
    step();
    if (scramble) begin
      dif.a = $urandom;
      dif.b = $urandom;
      dif.signed_div = ~s;
    end
    k = 0;
    busy_n = 0;
    while (k < 40) begin
      k++;
      if (dif.ready) break;
      if (dif.busy) busy_n++;
      step();
    end
    chk({tag, "_lat"}, 64'(k), (b == 32'd0) ? 64'd2 : 64'd33);
    chk({tag, "_busy"}, 64'(busy_n), (b == 32'd0) ? 64'd1 : 64'd32);
    chk({tag, "_res"}, dif.result, exp);
    dif.start = 1'b0;
    step();
    chk({tag, "_idle"}, {62'd0, dif.ready, dif.busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    logic [63:0] held;
    bit          saw_ready;
    bit          s;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    dif.start = 1'b0;
    dif.annul = 1'b0;
    dif.signed_div = 1'b0;
    dif.a = 32'd0;
    dif.b = 32'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_outs", {62'd0, dif.ready, dif.busy}, 64'd0);
    chk("rst_res", dif.result, 64'h0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    chk("divu_100_7_lit", dif.result, {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_m7_2_lit", dif.result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lit", dif.result, {32'h0, 32'h8000_0000});
    run_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("divu_max_lit", dif.result, {32'h0, 32'hFFFF_FFFF});
    run_div("div_zero", 1'b1, 32'd5, 32'd0, 1'b0);

    // annul together with start in IDLE keeps the block idle
    run_div("pre_annul", 1'b0, 32'd77, 32'd5, 1'b0);
    prev = ref_div(1'b0, 32'd77, 32'd5);
    dif.start = 1'b1;
    dif.annul = 1'b1;
    step();
    chk("annul_idle_start", {62'd0, dif.ready, dif.busy}, 64'd0);
    dif.annul = 1'b0;
    dif.start = 1'b0;
    step();

    // annul ten cycles after the start edge
    dif.signed_div = 1'b0;
    dif.a = 32'd1000;
    dif.b = 32'd3;
    dif.start = 1'b1;
    step();
    repeat (9) step();
    chk("annul_busy_before", {63'd0, dif.busy}, 64'd1);
    dif.annul = 1'b1;
    dif.start = 1'b0;
    step();
    dif.annul = 1'b0;
    chk("annul_outs", {62'd0, dif.ready, dif.busy}, 64'd0);
    chk("annul_res", dif.result, prev);
    saw_ready = 1'b0;
    repeat (40) begin
      step();
      if (dif.ready) saw_ready = 1'b1;
    end
    chk("annul_no_ready", {63'd0, saw_ready}, 64'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0);
    chk("divu_9_3_lit", dif.result, {32'd0, 32'd3});

    // stall: start held past ready
    dif.signed_div = 1'b1;
    dif.a = 32'd12345;
    dif.b = 32'hFFFF_FFF0;
    dif.start = 1'b1;
    step();
    repeat (32) step();
    chk("stall_ready0", {63'd0, dif.ready}, 64'd1);
    held = dif.result;
    chk("stall_res", held, ref_div(1'b1, 32'd12345, 32'hFFFF_FFF0));
    dif.a = 32'd7;
    dif.b = 32'd0;
    repeat (3) begin
      step();
      chk("stall_ready", {62'd0, dif.ready, dif.busy}, 64'd2);
      chk("stall_hold", dif.result, held);
    end
    dif.start = 1'b0;
    step();
    chk("stall_release", {62'd0, dif.ready, dif.busy}, 64'd0);
    chk("stall_release_res", dif.result, held);

    // randomized operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      s  = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        3: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if (i % 5 == 0) ra = 32'h8000_0000;
      run_div("rand", s, ra, rb, 1'(i % 2));
    end

    // reset during a divide
    dif.signed_div = 1'b0;
    dif.a = 32'd500;
    dif.b = 32'd6;
    dif.start = 1'b1;
    step();
    repeat (5) step();
    dif.start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_outs", {62'd0, dif.ready, dif.busy}, 64'd0);
    chk("rst_mid_res", dif.result, 64'h0);
    step();
    chk("rst_mid_stay", {62'd0, dif.ready, dif.busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage of the MIPS pipeline. It executes the DIV and DIVU operations that the ALU decoder selects. It takes the rs/rt operands, runs a 32-iteration restoring shift-subtract, and returns {remainder, quotient} for the HI/LO write. While a divide is in flight the pipeline stalls on start & ~ready.

## Interface
Parameters: none. Width is fixed at 32-bit operands and a 64-bit result.

Clocking: one clock; reset is synchronous and active-high.

- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- start  input  1  divide request. Asserted by EX while alucontrol is DIV/DIVU and held until ready.
- annul  input  1  flush/exception cancel. Highest priority after rst.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- a  input  32  dividend (rs value).
- b  input  32  divisor (rt value).
- result  output  64  {remainder[63:32] → HI, quotient[31:0] → LO}. Registered.
- ready  output  1  result valid.
- busy  output  1  high in BUSY and DIVZERO states.

## Operation
- States:
  - IDLE: ready=0, busy=0.
  - DIVZERO: busy=1.
  - BUSY: busy=1, 6-bit iteration counter.
  - DONE: ready=1.
- IDLE:
  - On start & ~annul, latch a, b, signed_div.
  - If b==0, go to DIVZERO.
  - Otherwise go to BUSY with counter=0, partial remainder=0, shift register=|a|.
- Magnitude rule:
  - Signed mode: |x| = x[31] ? -x : x, computed in 32 bits. 0x80000000 maps to 0x80000000 as an unsigned value.
  - Unsigned mode: operands are used as-is.
- BUSY, each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract |b| from the 33-bit rem.
  - If the result is non-negative, keep it and set the quotient bit to 1.
  - Counter increments. After the 32nd iteration (counter==31 at the edge), go to DONE.
- Sign fix-up, applied when entering DONE:
  - Signed mode only: quotient is negated iff a[31]^b[31]; remainder is negated iff a[31]. This gives truncation toward zero.
  - The fixed-up value is written to result.
- DIVZERO: go to DONE next cycle with result=64'h0. The architectural value is UNPREDICTABLE; we define it as 0.
- DONE:
  - ready=1.
  - Stay in DONE while start=1, with no restart. This covers external pipeline stalls.
  - On start=0, go to IDLE next cycle.
- Operand changes on a/b/signed_div after latching are ignored.
- Dropping start mid-BUSY (without annul) does not cancel. The divide completes, DONE lasts one cycle, then the block returns to IDLE.

## Timing
- Reset: state=IDLE, ready=0, busy=0, result=64'h0, counter=0.
- rst has priority over everything, in any state.
- Latency, with start sampled high in IDLE at edge T:
  - Normal divide: BUSY during T+1..T+32; ready=1 and result valid from T+33.
  - Divide-by-zero: DIVZERO at T+1; ready=1 from T+2.
- annul:
  - Sampled at any edge, in any state, it forces IDLE at the next cycle, with ready=0 and busy=0.
  - result keeps its previous value.
  - annul & start together in IDLE: annul wins and the block stays IDLE.
- Back-to-back divides: start must be observed low for at least one cycle (DONE→IDLE) before the next divide can be accepted. EX guarantees this because the instruction advances.
- ready and result change only on the clk edge. There is no combinational path from a/b to outputs.

## Test plan
- Unsigned divide: DIVU a=100, b=7, start held.
  - ready rises exactly 33 cycles after the start edge.
  - result={32'd2, 32'd14}; busy=1 for 32 cycles.
- Signed remainder sign: DIV a=0xFFFFFFF9 (-7), b=2.
  - quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Signed overflow corner: DIV a=0x80000000, b=0xFFFFFFFF.
  - result={0x00000000, 0x80000000}.
- Unsigned max: DIVU a=0xFFFFFFFF, b=1.
  - result={0x00000000, 0xFFFFFFFF}.
- Divide by zero: DIV a=5, b=0.
  - busy for 1 cycle; ready at T+2; result=64'h0.
- Annul mid-divide: annul pulses for one cycle, 10 cycles after the start edge.
  - Back in IDLE next cycle; ready never asserts; result unchanged.
  - A new DIVU 9/3 then completes with {0, 3} at +33 cycles.
- Stall hold and reset:
  - Keep start high 3 cycles past ready: ready stays 1, result stable, no new computation.
  - Drop start: IDLE next cycle.
  - Assert rst mid-BUSY: all outputs return to reset values next cycle.
